// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared constants and types for the memory-mapped timer
package timer_counter_pkg;

  // Register selects decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // Mode encodings; 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - programmable down-counting timer with one-shot/auto-reload and irq
import timer_counter_pkg::*;

module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pend;
  state_t      state;
  state_t      state_nxt;
  logic [31:0] count_nxt;
  logic        irq_set;
  logic        en_clr;
  logic        pend_pulse_clr;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        enable;
  logic        reload_mode;
  logic        unused_addr_bits;

  assign wr_ctrl     = we && (addr[3:2] == REG_CTRL);
  assign wr_preset   = we && (addr[3:2] == REG_PRESET);
  assign enable      = ctrl[CTRL_EN];
  assign reload_mode = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  // Only addr[3:2] selects a register; the remaining bits are don't-care
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  // Next-state and counter datapath for the four-state controller
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    irq_set        = 1'b0;
    en_clr         = 1'b0;
    pend_pulse_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          state_nxt = ST_INT;
          irq_set   = 1'b1;
        end
      end
      ST_INT: begin
        state_nxt = ST_IDLE;
        // One-shot stops itself; auto-reload keeps enable so IDLE reloads,
        // and its pending flag is only a single-cycle pulse.
        if (reload_mode) pend_pulse_clr = 1'b1;
        else             en_clr         = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A new preset restarts the sequence from IDLE; the value is picked up by the next LOAD
    if (wr_preset) state_nxt = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= 32'd0;
    else       count <= count_nxt;
  end

  // CTRL register; a CPU write takes priority over the one-shot self-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ctrl          <= 4'd0;
    else if (wr_ctrl) ctrl          <= din[3:0];
    else if (en_clr)  ctrl[CTRL_EN] <= 1'b0;
  end

  // PRESET register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          preset <= 32'd0;
    else if (wr_preset) preset <= din;
  end

  // Pending interrupt: software acknowledge by CTRL/PRESET write beats a new set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       irq_pend <= 1'b0;
    else if (wr_ctrl || wr_preset)   irq_pend <= 1'b0;
    else if (irq_set)                irq_pend <= 1'b1;
    else if (pend_pulse_clr)         irq_pend <= 1'b0;
  end

  // Combinational read mux
  always_comb begin
    dout = 32'd0;
    case (addr[3:2])
      REG_CTRL:   dout = {28'd0, ctrl};
      REG_PRESET: dout = preset;
      REG_COUNT:  dout = count;
      default:    dout = 32'd0;
    endcase
  end

  assign irq = irq_pend & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - scoreboard bench for timer_counter
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_PRESET = 32'h4;
  localparam logic [31:0] A_COUNT  = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;

  typedef struct {
    string       name;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, required finish within 200000 time units");
    $fatal(1);
  end

  // Monitor: compares every queued expectation against the outputs at the falling edge
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (dout !== it.exp_dout) begin
          errors++;
          $display("FAIL %s dout: got %h required %h", it.name, dout, it.exp_dout);
        end
        checks++;
        if (irq !== it.exp_irq) begin
          errors++;
          $display("FAIL %s irq: got %b required %b", it.name, irq, it.exp_irq);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e, input logic ei);
    exp_t it;
    addr        = a;
    it.name     = n;
    it.exp_dout = e;
    it.exp_irq  = ei;
    sb.push_back(it);
  endtask

  initial begin
    logic [31:0] ec;
    logic        ei;
    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'h0;
    din   = 32'h0;
    step();
    step();
    reset = 1'b0;

    chk("rst_ctrl", A_CTRL, 32'd0, 1'b0);     step();
    chk("rst_preset", A_PRESET, 32'd0, 1'b0); step();
    chk("rst_count", A_COUNT, 32'd0, 1'b0);   step();

    // Reset mid-count: mode 0, P=10, reset when COUNT reads 4
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    repeat (7) step();
    chk("t1_count5", A_COUNT, 32'd5, 1'b0);
    step();
    reset = 1'b1;
    chk("t1_rst_count", A_COUNT, 32'd0, 1'b0);
    step();
    chk("t1_rst_ctrl", A_CTRL, 32'd0, 1'b0);
    step();
    reset = 1'b0;

    // One-shot, IM=1, P=5
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    step(); step();
    chk("t2_count_p", A_COUNT, 32'd5, 1'b0);
    repeat (4) step();
    chk("t2_count1", A_COUNT, 32'd1, 1'b0);
    step();
    chk("t2_irq_rise", A_COUNT, 32'd0, 1'b1);
    step();
    chk("t2_en_clr", A_CTRL, 32'h8, 1'b1);
    step();
    chk("t2_irq_hold", A_COUNT, 32'd0, 1'b1);
    step();
    wr(A_PRESET, 32'd5);
    chk("t2_irq_drop", A_PRESET, 32'd5, 1'b0);
    step();

    // Auto-reload, IM=1, P=3: pulse every 6 cycles, COUNT 3,2,1,0,0,0
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k < 2) ec = 32'd0;
      else begin
        case ((k - 2) % 6)
          0:       ec = 32'd3;
          1:       ec = 32'd2;
          2:       ec = 32'd1;
          default: ec = 32'd0;
        endcase
      end
      ei = ((k % 6) == 5);
      chk($sformatf("t3_k%0d", k), A_COUNT, ec, ei);
    end
    step();
    wr(A_CTRL, 32'h0);
    step();

    // One-shot, P=8: disable lands as COUNT reaches 5, then re-enable reloads
    wr(A_PRESET, 32'd8);
    wr(A_CTRL, 32'h9);
    repeat (4) step();
    wr(A_CTRL, 32'h8);
    chk("t4_count5", A_COUNT, 32'd5, 1'b0);
    step();
    wr(A_COUNT, 32'hDEAD_BEEF);
    chk("t4_count_ro", A_COUNT, 32'd5, 1'b0);
    step();
    wr(A_RSVD, 32'hFFFF_FFFF);
    chk("t4_rsvd", A_RSVD, 32'd0, 1'b0);
    step();
    chk("t4_hold", A_COUNT, 32'd5, 1'b0);
    step();
    wr(A_CTRL, 32'h9);
    step(); step();
    chk("t4_reload", A_COUNT, 32'd8, 1'b0);
    step();
    chk("t4_dec", A_COUNT, 32'd7, 1'b0);
    step();
    wr(A_CTRL, 32'h0);
    step();

    // P=0 then P=1, mode 0: irq at t+3
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    step(); step();
    chk("t5_p0_t2", A_COUNT, 32'd0, 1'b0);
    step();
    chk("t5_p0_irq", A_COUNT, 32'd0, 1'b1);
    step();
    wr(A_PRESET, 32'd1);
    chk("t5_ack", A_PRESET, 32'd1, 1'b0);
    step();
    wr(A_CTRL, 32'h9);
    step(); step();
    chk("t5_p1_t2", A_COUNT, 32'd1, 1'b0);
    step();
    chk("t5_p1_irq", A_COUNT, 32'd0, 1'b1);
    step(); step();

    // IM=0, mode 0, P=2: irq stays low; setting IM later acknowledges
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      case (k)
        2:       ec = 32'd2;
        3:       ec = 32'd1;
        default: ec = 32'd0;
      endcase
      chk($sformatf("t6_k%0d", k), A_COUNT, ec, 1'b0);
    end
    step();
    chk("t6_en_clr", A_CTRL, 32'h0, 1'b0);
    step();
    wr(A_CTRL, 32'h8);
    chk("t6_im_set", A_CTRL, 32'h8, 1'b0);
    step();
    chk("t6_im_quiet", A_COUNT, 32'd0, 1'b0);

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
